lfsr_stream_encoder: RTL and testbench

- Parametrised successor to the dmem-driven LFSR encoder.
- Encrypts a message stream by XOR with a Fibonacci LFSR keystream. It first emits a programmable number of encrypted pad words, then one encrypted word per message word.
- Message input and ciphertext output use valid/ready handshakes; there are no memory address ports. Sits between the message source and the ciphertext sink.

---
 rtl/lfsr_stream_encoder.sv | 136 +++++++++++++
 tb/tb_lfsr_stream_encoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_encoder.sv
// Streams programmable pad words then message words, each XORed with a Fibonacci LFSR keystream.
// Optional macro PARITY_INSERT_EN replaces each message-word MSB with even parity of its low bits.
module lfsr_stream_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned PAD_W = 6,
  parameter logic [WIDTH-1:0] PAD_CHAR = WIDTH'(8'hA0)
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_tap,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [PAD_W-1:0] cfg_pad_len,
  input  logic [LEN_W-1:0] cfg_msg_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StPad, StMsg, StFlush} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] tap_q, tap_d;
  logic [PAD_W-1:0] pad_cnt_q, pad_cnt_d;
  logic [LEN_W-1:0] msg_cnt_q, msg_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             done_q, done_d;

  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] msg_word;

`ifdef PARITY_INSERT_EN
  assign msg_word = {^in_data[WIDTH-2:0], in_data[WIDTH-2:0]};
`else
  assign msg_word = in_data;
`endif

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    tap_d       = tap_q;
    pad_cnt_d   = pad_cnt_q;
    msg_cnt_d   = msg_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    load        = 1'b0;
    load_word   = '0;
    in_ready    = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tap_d     = cfg_tap;
          lfsr_d    = cfg_seed;
          pad_cnt_d = cfg_pad_len;
          msg_cnt_d = cfg_msg_len;
          if (cfg_pad_len != '0)      state_d = StPad;
          else if (cfg_msg_len != '0) state_d = StMsg;
          else                        state_d = StFlush;
        end
      end
      StPad: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = PAD_CHAR;
          pad_cnt_d = pad_cnt_q - 1'b1;
          if (pad_cnt_q == PAD_W'(1)) state_d = (msg_cnt_q != '0) ? StMsg : StFlush;
        end
      end
      StMsg: begin
        in_ready = can_load;
        if (in_valid && can_load) begin
          load      = 1'b1;
          load_word = msg_word;
          msg_cnt_d = msg_cnt_q - 1'b1;
          if (msg_cnt_q == LEN_W'(1)) state_d = StFlush;
        end
      end
      StFlush: begin
        // done is registered; hold FLUSH for the pulse cycle, then return to IDLE
        if (done_q)                          state_d = StIdle;
        else if (!out_valid_q || out_ready) done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_word ^ lfsr_q;
      lfsr_d      = {lfsr_q[WIDTH-2:0], ^(lfsr_q & tap_q)};
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= StIdle;
      lfsr_q      <= '0;
      tap_q       <= '0;
      pad_cnt_q   <= '0;
      msg_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      tap_q       <= tap_d;
      pad_cnt_q   <= pad_cnt_d;
      msg_cnt_q   <= msg_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_lfsr_stream_encoder.sv
// Directed bench for lfsr_stream_encoder: scoreboard of expected ciphertext words plus
// directed timing checks on done/busy/in_ready; honours PARITY_INSERT_EN like the design.
module tb_lfsr_stream_encoder;

  logic       clk = 1'b0;
  logic       init_n;
  logic       start;
  logic [7:0] cfg_tap, cfg_seed;
  logic [5:0] cfg_pad_len;
  logic [7:0] cfg_msg_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       done;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb[$];

  lfsr_stream_encoder dut (
    .clk        (clk),
    .init_n     (init_n),
    .start      (start),
    .cfg_tap    (cfg_tap),
    .cfg_seed   (cfg_seed),
    .cfg_pad_len(cfg_pad_len),
    .cfg_msg_len(cfg_msg_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] t);
    return {s[6:0], ^(s & t)};
  endfunction

  function automatic logic [7:0] enc(input logic [7:0] d);
`ifdef PARITY_INSERT_EN
    return {^d[6:0], d[6:0]};
`else
    return d;
`endif
  endfunction

  function automatic logic [7:0] msgw(input int i);
    return 8'(8'h30 + i * 7);
  endfunction

  // Sink-side scoreboard: a word is consumed at the next rising edge when valid&&ready here.
  always @(negedge clk) begin
    if (init_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_word: observed %0h expected none", out_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("out_word", 32'(out_data), 32'(e));
      end
    end
  end

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic set_cfg(input logic [7:0] t, input logic [7:0] s, input logic [5:0] p,
                         input logic [7:0] m);
    cfg_tap = t; cfg_seed = s; cfg_pad_len = p; cfg_msg_len = m;
  endtask

  initial begin
    int         cyc;
    int         idx;
    logic       hs;
    logic [7:0] s;

    init_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    set_cfg(8'h00, 8'h00, 6'd0, 8'd0);
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    tick();
    init_n = 1'b1;
    tick();

    // Two pad words, no message
    out_ready = 1'b1;
    sb.push_back(8'hA1); sb.push_back(8'hA2);
    set_cfg(8'hB8, 8'h01, 6'd2, 8'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("pad_first", 32'(out_data), 32'hA1);
    tick();
    check("pad_done_early", 32'(done), 0);
    tick();
    check("pad_done_pulse", 32'(done), 1);
    tick();
    check("pad_done_clear", 32'(done), 0);
    check("pad_idle", 32'(busy), 0);

    // Single message word, one-cycle latency
    sb.push_back(8'h40);
    set_cfg(8'hB8, 8'h01, 6'd0, 8'd1);
    in_valid = 1'b1; in_data = 8'h41;
    start = 1'b1;
    tick(); start = 1'b0;
    check("msg1_in_ready", 32'(in_ready), 1);
    tick();
    check("msg1_valid", 32'(out_valid), 1);
    check("msg1_data", 32'(out_data), 32'h40);
    check("msg1_flush_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    tick();
    check("msg1_done", 32'(done), 1);
    tick(); tick();

    // Two words with a three-cycle sink stall on the first
    out_ready = 1'b0;
    sb.push_back(8'h40); sb.push_back(8'h40);
    set_cfg(8'hB8, 8'h01, 6'd0, 8'd2);
    in_valid = 1'b1; in_data = 8'h41;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    in_data = 8'h42;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_hold", 32'(out_data), 32'h40);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("stall_second", 32'(out_data), 32'h40);
    tick();
    check("stall_done", 32'(done), 1);
    tick(); tick();

    // Empty job: busy for two cycles, done, never valid
    set_cfg(8'hB8, 8'h01, 6'd0, 8'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    check("empty_busy0", 32'(busy), 1);
    check("empty_done0", 32'(done), 0);
    tick();
    check("empty_busy1", 32'(busy), 1);
    check("empty_done1", 32'(done), 1);
    check("empty_valid", 32'(out_valid), 0);
    tick();
    check("empty_busy2", 32'(busy), 0);
    check("empty_done2", 32'(done), 0);

    // Reset in the middle of PAD, then rerun identical job
    out_ready = 1'b0;
    set_cfg(8'hB8, 8'h01, 6'd2, 8'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("abort_pre_data", 32'(out_data), 32'hA1);
    init_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    tick();
    init_n = 1'b1;
    tick();
    check("abort_no_done", 32'(done), 0);
    out_ready = 1'b1;
    sb.push_back(8'hA1); sb.push_back(8'hA2);
    start = 1'b1;
    tick(); start = 1'b0;
    wait_done(20);
    tick(); tick();

    // Zero seed: keystream is zero, pad untouched, message optionally parity-filled
    sb.push_back(8'hA0);
`ifdef PARITY_INSERT_EN
    sb.push_back(8'h87);
`else
    sb.push_back(8'h07);
`endif
    set_cfg(8'hB8, 8'h00, 6'd1, 8'd1);
    in_valid = 1'b1; in_data = 8'h07;
    start = 1'b1;
    tick(); start = 1'b0;
    wait_done(20);
    in_valid = 1'b0;
    tick(); tick();

    // Longer job at full rate; cfg changes and a stray start while busy are ignored
    s = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'hA0 ^ s);
      s = step(s, 8'hB8);
    end
    for (int i = 0; i < 5; i++) begin
      sb.push_back(enc(msgw(i)) ^ s);
      s = step(s, 8'hB8);
    end
    set_cfg(8'hB8, 8'h5A, 6'd3, 8'd5);
    idx = 0;
    in_valid = 1'b1; in_data = msgw(0);
    start = 1'b1;
    tick(); start = 1'b0;
    set_cfg(8'h03, 8'hFF, 6'd1, 8'd1);
    cyc = 0;
    while (!done && cyc < 60) begin
      hs = in_valid && in_ready;
      tick();
      cyc++;
      if (hs) begin
        idx++;
        in_data = msgw(idx);
      end
      start = (cyc == 3);
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("tput_cycles", 32'(cyc), 32'd9);
    check("tput_words_in", 32'(idx), 32'd5);
    tick(); tick();
    check("tput_idle", 32'(busy), 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
